// File: rtl/nios_hps_system_pll_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the system reset; re-pulses on lock timeout or lock loss.
module nios_hps_system_pll_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       status_clear,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       lock_lost,
  output logic [7:0] relock_count
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [15:0] RST_LAST     = 16'(RST_PULSE_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic        sync1_q, sync2_q;
  logic        lk;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        relock_evt, loss_evt;
  logic        pll_rst_q, sys_reset_n_q, lock_lost_q, lock_lost_d;
  logic [7:0]  relock_q, relock_d;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign lk = sync2_q;

  // Next-state and event decode
  always_comb begin
    state_d    = state_q;
    relock_evt = 1'b0;
    loss_evt   = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        else                   state_d = RESET_PLL;
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = RESET_PLL;
          relock_evt = 1'b1;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lk)                       state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
        else                           state_d = STABLE;
      end
      RUN: begin
        if (!lk) begin
          state_d    = RESET_PLL;
          relock_evt = 1'b1;
          loss_evt   = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RESET_PLL;
    endcase
  end

  // Shared timer restarts on every state change and holds at full scale in RUN
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)     cnt_d = 16'd0;
    else if (cnt_q == 16'hFFFF) cnt_d = cnt_q;
    else                        cnt_d = cnt_q + 16'd1;
  end

  // Status update: a same-cycle event takes precedence over the clear
  always_comb begin
    relock_d    = relock_q;
    lock_lost_d = lock_lost_q;
    if (relock_evt) relock_d = status_clear ? 8'd1 : sat_inc8(relock_q);
    else if (status_clear) relock_d = 8'd0;
    else relock_d = relock_q;
    if (loss_evt) lock_lost_d = 1'b1;
    else if (status_clear) lock_lost_d = 1'b0;
    else lock_lost_d = lock_lost_q;
  end

  // State and timer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_PLL;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs registered from the next state so they change on the transition edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      lock_lost_q   <= 1'b0;
      relock_q      <= 8'd0;
    end else begin
      pll_rst_q     <= (state_d == RESET_PLL);
      sys_reset_n_q <= (state_d == RUN);
      lock_lost_q   <= lock_lost_d;
      relock_q      <= relock_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_reset_n  = sys_reset_n_q;
  assign lock_lost    = lock_lost_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_nios_hps_system_pll_supervisor.sv
// Bench for the PLL supervisor: directed table, corner sequences and a
// randomized run against a timing-level reference model.
module tb_nios_hps_system_pll_supervisor;

  localparam int RST = 4;
  localparam int STB = 8;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       status_clear;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       lock_lost;
  logic [7:0] relock_count;

  always #5 clk = ~clk;

  nios_hps_system_pll_supervisor #(
    .RST_PULSE_CYCLES   (RST),
    .LOCK_STABLE_CYCLES (STB),
    .LOCK_TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .status_clear(status_clear),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .lock_lost   (lock_lost),
    .relock_count(relock_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0=pll pulse, 1=waiting, 2=qualifying, 3=running.
  // Lock is seen two edges late; time spent in a phase is tracked as an age.
  int   m_phase, m_age, m_relock;
  bit   m_lost;
  bit   m_hist[$];

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_relock = 0; m_lost = 1'b0;
    m_hist.delete();
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
  endtask

  task automatic model_step(input bit locked, input bit clr);
    bit seen;
    int nxt;
    bit evt, lost_evt;
    seen = m_hist[0];
    nxt = m_phase; evt = 0; lost_evt = 0;
    if (m_phase == 0) begin
      if (m_age + 1 >= RST) nxt = 1;
    end else if (m_phase == 1) begin
      if (seen) nxt = 2;
      else if (m_age + 1 >= TMO) begin nxt = 0; evt = 1; end
    end else if (m_phase == 2) begin
      if (!seen) nxt = 1;
      else if (m_age + 1 >= STB) nxt = 3;
    end else begin
      if (!seen) begin nxt = 0; evt = 1; lost_evt = 1; end
    end
    m_age = (nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
    if (clr) m_relock = 0;
    if (evt) m_relock = (m_relock + 1 > 255) ? 255 : m_relock + 1;
    if (clr) m_lost = 1'b0;
    if (lost_evt) m_lost = 1'b1;
    void'(m_hist.pop_front());
    m_hist.push_back(locked);
  endtask

  task automatic step(input logic lk_in, input logic clr);
    pll_locked   = lk_in;
    status_clear = clr;
    @(posedge clk);
    model_step(lk_in, clr);
    #1;
  endtask

  task automatic do_reset(input logic lk_in);
    pll_locked   = lk_in;
    status_clear = 1'b0;
    reset_n      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset pll_rst", pll_rst, 1);
    chk("reset sys_reset_n", sys_reset_n, 0);
    chk("reset lock_lost", lock_lost, 0);
    chk("reset relock_count", relock_count, 0);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       lk;
    logic       clr;
    int         cyc;
    logic       e_rst;
    logic       e_srn;
    logic       e_lost;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int srn_hi;
    int hold;
    logic lvl;
    logic clr;

    reset_n = 1'b0; pll_locked = 1'b0; status_clear = 1'b0;

    // Power-up, lock, lock loss, relock and clear, applied from reset release
    tbl[0]  = '{1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 5,  1'b0, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b1, 8'd1};
    tbl[8]  = '{1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b1, 8'd1};
    tbl[9]  = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 8'd1};
    tbl[10] = '{1'b1, 1'b0, 8,  1'b0, 1'b0, 1'b1, 8'd1};
    tbl[11] = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1, 8'd1};
    tbl[12] = '{1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b0, 8'd0};
    tbl[13] = '{1'b1, 1'b0, 3,  1'b0, 1'b1, 1'b0, 8'd0};

    do_reset(1'b0);
    for (int i = 0; i < 14; i++) begin
      for (int c = 0; c < tbl[i].cyc; c++) step(tbl[i].lk, tbl[i].clr);
      chk($sformatf("vec%0d pll_rst", i), pll_rst, tbl[i].e_rst);
      chk($sformatf("vec%0d sys_reset_n", i), sys_reset_n, tbl[i].e_srn);
      chk($sformatf("vec%0d lock_lost", i), lock_lost, tbl[i].e_lost);
      chk($sformatf("vec%0d relock_count", i), relock_count, tbl[i].e_cnt);
    end

    // Lock bounce seen at stable count 5: qualification restarts from zero
    do_reset(1'b1);
    srn_hi = 0;
    for (int e = 1; e <= 20; e++) begin
      step((e == 9 || e == 10) ? 1'b0 : 1'b1, 1'b0);
      if (sys_reset_n) srn_hi = 1;
    end
    chk("bounce sys_reset_n held low", srn_hi, 0);
    chk("bounce relock_count", relock_count, 0);
    step(1'b1, 1'b0);
    chk("bounce run after restart", sys_reset_n, 1);

    // Lock loss in RUN: system reset falls on the third edge after the drop
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("loss1 sys_reset_n before fall", sys_reset_n, 1);
    step(1'b0, 1'b0);
    chk("loss1 sys_reset_n", sys_reset_n, 0);
    chk("loss1 relock_count", relock_count, 1);
    chk("loss1 lock_lost", lock_lost, 1);
    repeat (13) step(1'b1, 1'b0);
    chk("loss1 back in run", sys_reset_n, 1);

    // Asynchronous reset in the middle of a RUN cycle
    reset_n = 1'b0;
    #1;
    chk("async pll_rst", pll_rst, 1);
    chk("async sys_reset_n", sys_reset_n, 0);
    chk("async lock_lost", lock_lost, 0);
    chk("async relock_count", relock_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) step(1'b1, 1'b0);
    chk("restart pll_rst edge3", pll_rst, 1);
    step(1'b1, 1'b0);
    chk("restart pll_rst edge4", pll_rst, 0);
    repeat (8) step(1'b1, 1'b0);
    chk("restart sys_reset_n edge12", sys_reset_n, 0);
    step(1'b1, 1'b0);
    chk("restart sys_reset_n edge13", sys_reset_n, 1);
    chk("restart relock_count", relock_count, 0);

    // Second loss, then a third loss coinciding with status_clear
    repeat (3) step(1'b0, 1'b0);
    chk("loss2 relock_count", relock_count, 1);
    repeat (13) step(1'b1, 1'b0);
    chk("loss2 back in run", sys_reset_n, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("clear+event relock_count", relock_count, 1);
    chk("clear+event lock_lost", lock_lost, 1);
    repeat (13) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("clear relock_count", relock_count, 0);
    chk("clear lock_lost", lock_lost, 0);
    chk("clear sys_reset_n", sys_reset_n, 1);

    // Lock never arrives: re-pulse every RST+TMO cycles, count saturates
    do_reset(1'b0);
    for (int k = 1; k <= 300; k++) begin
      for (int j = 1; j <= RST + TMO; j++) begin
        step(1'b0, 1'b0);
        if (j == RST - 1) chk($sformatf("tmo%0d pulse tail", k), pll_rst, 1);
        if (j == RST) chk($sformatf("tmo%0d pulse end", k), pll_rst, 0);
        if (j == RST + TMO - 1) chk($sformatf("tmo%0d wait end", k), pll_rst, 0);
        if (j == RST + TMO) begin
          chk($sformatf("tmo%0d re-pulse", k), pll_rst, 1);
          chk($sformatf("tmo%0d relock_count", k), relock_count, (k > 255) ? 255 : k);
        end
      end
    end

    // Randomized lock behaviour and clears against the reference model
    do_reset(1'b0);
    hold = 0;
    lvl  = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (hold == 0) begin
        lvl  = 1'($urandom_range(0, 1));
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                           : int'($urandom_range(10, 60));
      end
      hold--;
      if ($urandom_range(0, 1499) == 0) do_reset(lvl);
      clr = ($urandom_range(0, 19) == 0);
      step(lvl, clr);
      chk("rand pll_rst", pll_rst, (m_phase == 0) ? 1 : 0);
      chk("rand sys_reset_n", sys_reset_n, (m_phase == 3) ? 1 : 0);
      chk("rand lock_lost", lock_lost, m_lost);
      chk("rand relock_count", relock_count, m_relock);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
